bin_to_bcd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Successor to the combinational 12-bit converter. Adds configurable input width and digit count, a start/busy/done handshake, an overflow flag and a leading-zero mask.
- Sits between arithmetic/counter logic and the 7-segment digit decoders; its outputs feed the display scanner directly.

---
 rtl/bin_to_bcd_seq.sv | 104 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Adds start/busy/done handshake, overflow detection and a leading-zero mask.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset_p,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                overflow,
    output logic [DIGITS-1:0]   nz_mask
);
    localparam int unsigned       SW     = 4 * DIGITS;
    localparam int unsigned       CW     = $clog2(BIN_W + 1);
    localparam logic [CW-1:0]     LAST   = CW'(BIN_W - 1);
    localparam logic [DIGITS-1:0] NZ_RST = DIGITS'(1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q;
    logic [BIN_W-1:0]  shift_q;
    logic [SW-1:0]     scratch_q;
    logic [CW-1:0]     cnt_q;
    logic              ovf_acc_q;

    logic [SW-1:0]     corrected;
    logic [SW-1:0]     scratch_d;
    logic [BIN_W-1:0]  shift_d;
    logic              out_bit;
    logic [DIGITS-1:0] nz_d;
    logic              any_nz;

    // All digits are corrected in parallel on pre-shift values, then shifted once.
    always_comb begin
        corrected = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                corrected[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        out_bit   = corrected[SW-1];
        scratch_d = {corrected[SW-2:0], shift_q[BIN_W-1]};
        shift_d   = {shift_q[BIN_W-2:0], 1'b0};
    end

    always_comb begin
        any_nz = 1'b0;
        nz_d   = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            any_nz  = any_nz | (|scratch_d[4*i +: 4]);
            nz_d[i] = any_nz;
        end
        nz_d[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            overflow  <= 1'b0;
            nz_mask   <= NZ_RST;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        shift_q   <= bin;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        ovf_acc_q <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    shift_q   <= shift_d;
                    scratch_q <= scratch_d;
                    ovf_acc_q <= ovf_acc_q | out_bit;
                    cnt_q     <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        bcd      <= scratch_d;
                        overflow <= ovf_acc_q | out_bit;
                        nz_mask  <= nz_d;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: three instances (12/4, 8/2, 16/4) checked
// against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;
    typedef struct packed {
        logic [39:0] bcd;
        logic        ovf;
        logic [9:0]  nz;
    } exp_t;

    logic clk = 1'b0;
    logic reset_p;

    logic        start_a, busy_a, done_a, ovf_a;
    logic [11:0] bin_a;
    logic [15:0] bcd_a;
    logic [3:0]  nz_a;

    logic        start_b, busy_b, done_b, ovf_b;
    logic [7:0]  bin_b;
    logic [7:0]  bcd_b;
    logic [1:0]  nz_b;

    logic        start_c, busy_c, done_c, ovf_c;
    logic [15:0] bin_c;
    logic [15:0] bcd_c;
    logic [3:0]  nz_c;

    int errors = 0;
    int checks = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t e_a, e_b, e_c;
    exp_t pend_a;
    logic [15:0] last_a = '0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut_a (
        .clk(clk), .reset_p(reset_p), .start(start_a), .bin(bin_a), .busy(busy_a),
        .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .nz_mask(nz_a)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
        .clk(clk), .reset_p(reset_p), .start(start_b), .bin(bin_b), .busy(busy_b),
        .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .nz_mask(nz_b)
    );

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut_c (
        .clk(clk), .reset_p(reset_p), .start(start_c), .bin(bin_c), .busy(busy_c),
        .done(done_c), .bcd(bcd_c), .overflow(ovf_c), .nz_mask(nz_c)
    );

    // Reference: decimal digits by division, overflow by magnitude comparison.
    function automatic exp_t model(longint unsigned v, int d);
        exp_t e;
        longint unsigned r = v;
        longint unsigned p = 1;
        longint unsigned low;
        e = '0;
        for (int i = 0; i < d; i++) begin
            e.bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
            p = p * 10;
        end
        e.ovf = (v >= p);
        low = v % p;
        p = 1;
        for (int i = 0; i < d; i++) begin
            e.nz[i] = (low >= p);
            p = p * 10;
        end
        e.nz[0] = 1'b1;
        return e;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int width_of(int idx);
        return (idx == 0) ? 12 : (idx == 1) ? 8 : 16;
    endfunction

    function automatic int digits_of(int idx);
        return (idx == 1) ? 2 : 4;
    endfunction

    function automatic logic done_of(int idx);
        return (idx == 0) ? done_a : (idx == 1) ? done_b : done_c;
    endfunction

    function automatic logic busy_of(int idx);
        return (idx == 0) ? busy_a : (idx == 1) ? busy_b : busy_c;
    endfunction

    task automatic drive(int idx, logic s, longint unsigned v);
        case (idx)
            0: begin start_a = s; bin_a = v[11:0]; end
            1: begin start_b = s; bin_b = v[7:0]; end
            default: begin start_c = s; bin_c = v[15:0]; end
        endcase
    endtask

    // Presents start for one edge; the bin bus is scrambled afterwards.
    task automatic start_conv(int idx, longint unsigned v, bit push);
        exp_t e;
        e = model(v, digits_of(idx));
        @(negedge clk);
        drive(idx, 1'b1, v);
        if (push) begin
            case (idx)
                0: begin q_a.push_back(e); pend_a = e; end
                1: q_b.push_back(e);
                default: q_c.push_back(e);
            endcase
        end
        @(posedge clk);
        #1;
        drive(idx, 1'b0, longint'($urandom));
        check("busy_after_start", 64'(busy_of(idx)), 64'd1);
    endtask

    task automatic wait_done(int idx, output int n, output int bcnt);
        bit got = 0;
        n = 0;
        bcnt = 1;
        while (!got && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done_of(idx)) begin
                got = 1;
                check("busy_at_done", 64'(busy_of(idx)), 64'd0);
                if (idx == 0) last_a = pend_a.bcd[15:0];
            end else begin
                if (busy_of(idx)) bcnt++;
                if (idx == 0) check("a_hold_bcd", 64'(bcd_a), 64'(last_a));
            end
        end
        if (!got) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic convert(int idx, longint unsigned v);
        int n, bcnt;
        start_conv(idx, v, 1'b1);
        wait_done(idx, n, bcnt);
        check("latency", 64'(n), 64'(width_of(idx)));
        check("busy_cycles", 64'(bcnt), 64'(width_of(idx)));
    endtask

    always @(negedge clk) begin
        if (done_a) begin
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_spurious_done: got done=1 expected done=0 at %0t", $time);
            end else begin
                e_a = q_a.pop_front();
                check("a_bcd", 64'(bcd_a), 64'(e_a.bcd[15:0]));
                check("a_ovf", 64'(ovf_a), 64'(e_a.ovf));
                check("a_nz", 64'(nz_a), 64'(e_a.nz[3:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (done_b) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_spurious_done: got done=1 expected done=0 at %0t", $time);
            end else begin
                e_b = q_b.pop_front();
                check("b_bcd", 64'(bcd_b), 64'(e_b.bcd[7:0]));
                check("b_ovf", 64'(ovf_b), 64'(e_b.ovf));
                check("b_nz", 64'(nz_b), 64'(e_b.nz[1:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (done_c) begin
            if (q_c.size() == 0) begin
                checks++; errors++;
                $display("FAIL c_spurious_done: got done=1 expected done=0 at %0t", $time);
            end else begin
                e_c = q_c.pop_front();
                check("c_bcd", 64'(bcd_c), 64'(e_c.bcd[15:0]));
                check("c_ovf", 64'(ovf_c), 64'(e_c.ovf));
                check("c_nz", 64'(nz_c), 64'(e_c.nz[3:0]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, bcnt;
        reset_p = 1'b1;
        start_a = 0; start_b = 0; start_c = 0;
        bin_a = '0; bin_b = '0; bin_c = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_p = 1'b0;
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_bcd", 64'(bcd_a), 64'd0);
        check("rst_ovf", 64'(ovf_a), 64'd0);
        check("rst_nz", 64'(nz_a), 64'b0001);
        check("rst_nz_b", 64'(nz_b), 64'b01);

        convert(0, 0);
        convert(0, 1234);
        convert(0, 4095);
        convert(0, 7);

        convert(1, 255);
        convert(1, 99);
        convert(1, 100);
        convert(1, 9);

        // Start while busy is ignored; start in the done cycle is accepted.
        start_conv(0, 1234, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        drive(0, 1'b1, 999);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 0);
        wait_done(0, n, bcnt);
        check("ignored_start_latency", 64'(n), 64'd7);
        start_conv(0, 42, 1'b1);
        wait_done(0, n, bcnt);
        check("done_cycle_start_latency", 64'(n), 64'd12);

        // Reset mid-conversion aborts without a done pulse.
        convert(0, 321);
        start_conv(0, 4000, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_p = 1'b1;
        @(posedge clk);
        #1;
        reset_p = 1'b0;
        last_a = '0;
        check("abort_busy", 64'(busy_a), 64'd0);
        check("abort_done", 64'(done_a), 64'd0);
        check("abort_bcd", 64'(bcd_a), 64'd0);
        check("abort_ovf", 64'(ovf_a), 64'd0);
        check("abort_nz", 64'(nz_a), 64'b0001);
        repeat (15) @(posedge clk);
        convert(0, 10);

        for (int i = 0; i < 40; i++) convert(0, longint'($urandom_range(0, 4095)));
        for (int i = 0; i < 20; i++) convert(1, longint'($urandom_range(0, 255)));
        convert(2, 0);
        convert(2, 9999);
        convert(2, 10000);
        convert(2, 65535);
        for (int i = 0; i < 25; i++) convert(2, longint'($urandom_range(0, 65535)));

        repeat (3) @(posedge clk);
        #1;
        check("queue_a_empty", 64'(q_a.size()), 64'd0);
        check("queue_b_empty", 64'(q_b.size()), 64'd0);
        check("queue_c_empty", 64'(q_c.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
